// File: rtl/cmp_seq_fp.sv
// ---------------------------------------------------------------------------
// cmp_seq_fp -- sequential magnitude comparator for the FP unit.
//
// Compares two WIDTH-bit operands as unsigned, two's-complement signed or
// IEEE-754 values. The scan covers CHUNK bits per cycle, MSB first, and stops
// at the first unequal chunk. Sign and NaN cases that can be decided from
// the operands alone finish at the accept edge without scanning.
//
// Optional feature: define CMP_MINMAX_EN to add min_o/max_o outputs with
// RISC-V FMIN/FMAX selection (NaN handling, -0 < +0).
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   valid_i  operands/mode valid           ready_o  block can accept (IDLE)
//   A_i/B_i  operands, WIDTH bits          mode_i   00 uns, 01 sgn, 10 FP, 11 uns
//   valid_o  result valid (DONE)           ready_i  consumer takes result
//   L_o/G_o/E_o  A<B / A>B / A==B          unord_o  FP unordered (NaN seen)
//   min_o/max_o  (CMP_MINMAX_EN only) smaller/larger operand
// ---------------------------------------------------------------------------
module cmp_seq_fp #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int EXP_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             L_o,
    output logic             G_o,
    output logic             E_o,
    output logic             unord_o
`ifdef CMP_MINMAX_EN
    ,
    output logic [WIDTH-1:0] min_o,
    output logic [WIDTH-1:0] max_o
`endif
);

    localparam int MAN_W  = WIDTH - 1 - EXP_W;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [1:0]        mode_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              l_reg, g_reg, e_reg, u_reg;

    // ---------------- operand classification at the input ----------------
    logic in_fp, in_signed, sign_a, sign_b, nan_a, nan_b, both_zero;

    assign in_fp     = (mode_i == 2'b10);
    assign in_signed = (mode_i == 2'b01);
    assign sign_a    = A_i[WIDTH-1];
    assign sign_b    = B_i[WIDTH-1];
    assign nan_a     = (&A_i[WIDTH-2 -: EXP_W]) & (|A_i[MAN_W-1:0]);
    assign nan_b     = (&B_i[WIDTH-2 -: EXP_W]) & (|B_i[MAN_W-1:0]);
    assign both_zero = ~(|A_i[WIDTH-2:0]) & ~(|B_i[WIDTH-2:0]);

    // Cases decided without scanning. For signed and FP with differing
    // signs the negative operand is the smaller one, except FP +0/-0.
    logic sc_hit, sc_l, sc_g, sc_e, sc_u;

    always_comb begin
        sc_hit = 1'b0;
        sc_l   = 1'b0;
        sc_g   = 1'b0;
        sc_e   = 1'b0;
        sc_u   = 1'b0;
        if (in_fp && (nan_a || nan_b)) begin
            sc_hit = 1'b1;
            sc_u   = 1'b1;
        end else if ((in_signed || in_fp) && (sign_a != sign_b)) begin
            sc_hit = 1'b1;
            if (in_fp && both_zero) begin
                sc_e = 1'b1;
            end else begin
                sc_l = sign_a;
                sc_g = sign_b;
            end
        end
    end

    // ---------------- chunk scan on the registered operands ----------------
    logic [CHUNK-1:0] a_chunk [NCHUNK];
    logic [CHUNK-1:0] b_chunk [NCHUNK];

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    logic chunk_lt, chunk_gt, neg_swap, scan_l, scan_g, scan_last;

    always_comb begin
        chunk_lt  = (a_chunk[idx_reg] < b_chunk[idx_reg]);
        chunk_gt  = (a_chunk[idx_reg] > b_chunk[idx_reg]);
        // Signs are equal whenever FP reaches the scan; for two negative
        // values the larger magnitude is the smaller number.
        neg_swap  = (mode_reg == 2'b10) & a_reg[WIDTH-1] & b_reg[WIDTH-1];
        scan_l    = neg_swap ? chunk_gt : chunk_lt;
        scan_g    = neg_swap ? chunk_lt : chunk_gt;
        scan_last = (idx_reg == '0);
    end

`ifdef CMP_MINMAX_EN
    localparam logic [WIDTH-1:0] MAN_MSB   = WIDTH'(1) << (MAN_W - 1);
    localparam logic [WIDTH-1:0] EXP_ONES  = ((WIDTH'(1) << EXP_W) - WIDTH'(1)) << MAN_W;
    localparam logic [WIDTH-1:0] CANON_NAN = EXP_ONES | MAN_MSB;

    logic [WIDTH-1:0] min_reg, max_reg;

    // Returns {min, max}.
    function automatic logic [2*WIDTH-1:0] pick_minmax(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             fp,
        input logic             l,
        input logic             e,
        input logic             na,
        input logic             nb
    );
        if (fp && na && nb)
            return {CANON_NAN, CANON_NAN};
        else if (fp && na)
            return {b, b};
        else if (fp && nb)
            return {a, a};
        else if (e) begin
            // Only +0/-0 can be equal with differing signs.
            if (fp && (a[WIDTH-1] != b[WIDTH-1]))
                return a[WIDTH-1] ? {a, b} : {b, a};
            return {a, a};
        end else if (l)
            return {a, b};
        else
            return {b, a};
    endfunction

    assign min_o = min_reg;
    assign max_o = max_reg;
`endif

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            mode_reg  <= '0;
            idx_reg   <= '0;
            l_reg     <= 1'b0;
            g_reg     <= 1'b0;
            e_reg     <= 1'b0;
            u_reg     <= 1'b0;
`ifdef CMP_MINMAX_EN
            min_reg   <= '0;
            max_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        a_reg    <= A_i;
                        b_reg    <= B_i;
                        mode_reg <= mode_i;
                        idx_reg  <= IDX_TOP;
                        if (sc_hit) begin
                            l_reg     <= sc_l;
                            g_reg     <= sc_g;
                            e_reg     <= sc_e;
                            u_reg     <= sc_u;
                            state_reg <= DONE;
`ifdef CMP_MINMAX_EN
                            {min_reg, max_reg} <= pick_minmax(A_i, B_i, in_fp,
                                                              sc_l, sc_e, nan_a, nan_b);
`endif
                        end else begin
                            state_reg <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (chunk_lt || chunk_gt || scan_last) begin
                        l_reg     <= scan_l;
                        g_reg     <= scan_g;
                        e_reg     <= ~(chunk_lt | chunk_gt);
                        u_reg     <= 1'b0;
                        state_reg <= DONE;
`ifdef CMP_MINMAX_EN
                        {min_reg, max_reg} <= pick_minmax(a_reg, b_reg, mode_reg == 2'b10,
                                                          scan_l, ~(chunk_lt | chunk_gt),
                                                          1'b0, 1'b0);
`endif
                    end else begin
                        idx_reg <= idx_reg - IDX_W'(1);
                    end
                end
                DONE: begin
                    if (ready_i) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready_o = (state_reg == IDLE);
    assign valid_o = (state_reg == DONE);
    assign L_o     = l_reg;
    assign G_o     = g_reg;
    assign E_o     = e_reg;
    assign unord_o = u_reg;

endmodule

// File: tb/tb_cmp_seq_fp.sv
// ---------------------------------------------------------------------------
// tb_cmp_seq_fp -- directed bench for cmp_seq_fp (WIDTH=32, CHUNK=8, EXP_W=8).
// Expected flags, latencies and min/max values are hand-computed constants.
// min/max checks are compiled in when CMP_MINMAX_EN is defined.
// ---------------------------------------------------------------------------
module tb_cmp_seq_fp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [1:0]  mode_in;
    logic        valid_out;
    logic        ready_in;
    logic        l_out, g_out, e_out, u_out;
`ifdef CMP_MINMAX_EN
    logic [31:0] min_out, max_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cmp_seq_fp #(.WIDTH(32), .CHUNK(8), .EXP_W(8)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_in),
        .ready_o (ready_out),
        .A_i     (a_in),
        .B_i     (b_in),
        .mode_i  (mode_in),
        .valid_o (valid_out),
        .ready_i (ready_in),
        .L_o     (l_out),
        .G_o     (g_out),
        .E_o     (e_out),
        .unord_o (u_out)
`ifdef CMP_MINMAX_EN
        ,
        .min_o   (min_out),
        .max_o   (max_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one operand pair, accept it, and return the number of edges
    // from the accept edge (counted as 1) until valid_o is seen high.
    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] m, output int lat);
        @(negedge clk);
        a_in = a; b_in = b; mode_in = m; valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // flags = {L, G, E, unord}
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] m, input int exp_lat, input logic [3:0] flags,
                         input logic [31:0] exp_min, input logic [31:0] exp_max,
                         input bit handoff);
        int lat;
        check({tag, "_rdy_in"}, {31'b0, ready_out}, 32'd1);
        launch(a, b, m, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_flags"}, {28'b0, l_out, g_out, e_out, u_out}, {28'b0, flags});
        check({tag, "_rdy_busy"}, {31'b0, ready_out}, 32'd0);
`ifdef CMP_MINMAX_EN
        check({tag, "_min"}, min_out, exp_min);
        check({tag, "_max"}, max_out, exp_max);
`else
        if (exp_min === 32'hxxxx_xxxx && exp_max === 32'hxxxx_xxxx) $display("note %s", tag);
`endif
        $display("op %s A=%h B=%h mode=%0d lat=%0d LGEU=%b%b%b%b", tag, a, b, m, lat,
                 l_out, g_out, e_out, u_out);
        if (handoff) begin
            ready_in = 1'b1;
            @(posedge clk);
            #1;
            ready_in = 1'b0;
            check({tag, "_idle"}, {30'b0, ready_out, valid_out}, 32'd2);
        end
    endtask

    initial begin
        bit seen_valid;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        a_in     = '0;
        b_in     = '0;
        mode_in  = '0;

        // Reset state
        #1;
        check("rst_ready", {31'b0, ready_out}, 32'd1);
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        check("rst_flags", {28'b0, l_out, g_out, e_out, u_out}, 32'd0);
`ifdef CMP_MINMAX_EN
        check("rst_min", min_out, 32'd0);
        check("rst_max", max_out, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full 4-chunk scan, last chunk decides
        do_op("t1_uns", 32'h12345678, 32'h12345679, 2'b00, 5, 4'b1000,
              32'h12345678, 32'h12345679, 1);
        // Signed shortcut vs unsigned scan
        do_op("t2_sgn", 32'hFFFFFFFF, 32'h00000001, 2'b01, 1, 4'b1000,
              32'hFFFFFFFF, 32'h00000001, 1);
        do_op("t2_uns", 32'hFFFFFFFF, 32'h00000001, 2'b00, 2, 4'b0100,
              32'h00000001, 32'hFFFFFFFF, 1);
        // Reserved mode behaves as unsigned
        do_op("t2_rsv", 32'hFFFFFFFF, 32'h00000001, 2'b11, 2, 4'b0100,
              32'h00000001, 32'hFFFFFFFF, 1);
        // FP: -0 == +0 shortcut, two negatives with swap, two positives
        do_op("t3_zero", 32'h80000000, 32'h00000000, 2'b10, 1, 4'b0010,
              32'h80000000, 32'h00000000, 1);
        do_op("t3_neg", 32'hBF800000, 32'hC0000000, 2'b10, 2, 4'b0100,
              32'hC0000000, 32'hBF800000, 1);
        do_op("t3_pos", 32'h3F800000, 32'h40000000, 2'b10, 2, 4'b1000,
              32'h3F800000, 32'h40000000, 1);
        // FP NaN: one NaN and both NaN
        do_op("t4_nan1", 32'h7FC00000, 32'h3F800000, 2'b10, 1, 4'b0001,
              32'h3F800000, 32'h3F800000, 1);
        do_op("t4_nan2", 32'h7FC00000, 32'hFF800001, 2'b10, 1, 4'b0001,
              32'h7FC00000, 32'h7FC00000, 1);

        // Back-pressure: result held with ready_i low, valid_i pulse ignored
        do_op("t5", 32'h00000005, 32'h00000003, 2'b00, 5, 4'b0100,
              32'h00000003, 32'h00000005, 0);
        @(negedge clk);
        a_in = 32'h0; b_in = 32'h0; mode_in = 2'b00; valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            check("t5_hold_valid", {31'b0, valid_out}, 32'd1);
            check("t5_hold_ready", {31'b0, ready_out}, 32'd0);
            check("t5_hold_flags", {28'b0, l_out, g_out, e_out, u_out}, 32'b0100);
        end
        // Hand-off with valid_i also high: must not accept on that edge
        @(negedge clk);
        ready_in = 1'b1;
        valid_in = 1'b1;
        a_in = 32'h1; b_in = 32'h2;
        @(posedge clk);
        #1;
        ready_in = 1'b0;
        valid_in = 1'b0;
        check("t5_release", {30'b0, ready_out, valid_out}, 32'd2);
        check("t5_flags_kept", {28'b0, l_out, g_out, e_out, u_out}, 32'b0100);
        @(posedge clk);
        #1;
        check("t5_no_accept", {30'b0, ready_out, valid_out}, 32'd2);
        $display("op t5 hold/bubble done");

        // Reset during the second scan cycle aborts the compare
        @(negedge clk);
        a_in = 32'hA5A5A5A5; b_in = 32'hA5A5A5A5; mode_in = 2'b00; valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("t6_scanning", {30'b0, ready_out, valid_out}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", {31'b0, ready_out}, 32'd1);
        check("t6_rst_flags", {28'b0, l_out, g_out, e_out, u_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen_valid |= valid_out;
        end
        check("t6_no_result", {31'b0, seen_valid}, 32'd0);
        $display("op t6 reset abort done");
        do_op("t6_eq", 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 5, 4'b0010,
              32'hA5A5A5A5, 32'hA5A5A5A5, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmp_seq_fp.md
Name: cmp_seq_fp

Overview:
Parametrised, sequential magnitude comparator for the RISC-V FP unit. Compares WIDTH-bit operands as unsigned, two's-complement signed, or IEEE-754 values. Scans CHUNK bits per cycle, MSB-first, and exits early on the first unequal chunk. Uses a valid/ready handshake on both sides, so it can sit between the FP decode stage and the FCMP/FMIN/FMAX writeback.

Parameters:
WIDTH, 32, operand width; must be a multiple of CHUNK.
CHUNK, 8, bits compared per scan cycle.
EXP_W, 8, FP exponent width; mantissa width MAN_W = WIDTH-1-EXP_W.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
valid_i  in  1  operands/mode valid
ready_o  out  1  block can accept
A_i  in  WIDTH  operand A
B_i  in  WIDTH  operand B
mode_i  in  2  00 unsigned, 01 signed, 10 FP, 11 reserved (treated as unsigned)
valid_o  out  1  result valid
ready_i  in  1  consumer accepts result
L_o  out  1  A less than B
G_o  out  1  A greater than B
E_o  out  1  A equal B
unord_o  out  1  FP unordered (either operand NaN)

Behaviour:
- One clock (clk_i). Reset rst_ni is asynchronous, active-low.
- Reset:
  - State goes to IDLE; all registers clear.
  - valid_o=0, L_o=G_o=E_o=unord_o=0, ready_o=1.
  - Reset asserted mid-scan aborts the operation; no result is produced.
- FSM states: IDLE, SCAN, DONE.
- ready_o = (state==IDLE). valid_o = (state==DONE). Result outputs are registered and stable for the whole DONE state.
- IDLE, accept on valid_i&ready_o:
  - Register A, B and mode.
  - Set idx = WIDTH/CHUNK-1.
  - Precompute sign bits, NaN flags (exponent all ones and mantissa nonzero) and a both-zero flag (magnitudes of A and B both 0).
- Shortcut cases (go directly to DONE at the accept edge):
  - FP and either operand NaN: unord=1, L=G=E=0.
  - Signed, signs differ: the negative operand is less.
  - FP, signs differ, both-zero: E=1 (+0 == -0).
  - FP, signs differ, otherwise: the positive operand is greater.
  - Otherwise the next state is SCAN.
- SCAN, each cycle: compare chunk idx of A and B as unsigned.
  - Unequal: go to DONE with L/G from that chunk. In FP mode with both signs negative, swap L and G.
  - Equal and idx==0: go to DONE with E=1.
  - Otherwise: idx decrements.
- Latency, counted in edges from the accept edge to valid_o high: shortcut = 1; scan = 1 + number of chunks scanned. Maximum = 1 + WIDTH/CHUNK.
- DONE:
  - Hold all outputs while ready_i=0.
  - On ready_i=1, go to IDLE and clear valid_o. Result flags stay unchanged until the next DONE.
  - One-cycle bubble between results: no accept in the same cycle as result hand-off.
- valid_i is ignored whenever ready_o=0. Input changes during SCAN/DONE have no effect.
- Exactly one of L/G/E/unord is 1 in DONE.

Optional Feature:
- Macro CMP_MINMAX_EN.
- When defined, adds two outputs: min_o out WIDTH and max_o out WIDTH. Both are registered on entry to DONE and reset to 0.
- Selection follows RISC-V FMIN/FMAX semantics in FP mode:
  - Exactly one NaN: return the other operand.
  - Both NaN: return canonical NaN (sign 0, exponent all ones, mantissa MSB 1, rest 0; 0x7FC00000 for WIDTH=32).
  - -0 vs +0: min = -0, max = +0.
- Non-FP modes return the smaller/larger operand per the mode's ordering; when E=1 both outputs equal A.
- When undefined, the ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. mode 00, A=0x12345678, B=0x12345679 -> 4 chunks scanned, valid_o 5 edges after accept, L_o=1, G_o=E_o=unord_o=0.
2. A=0xFFFFFFFF, B=0x00000001: mode 01 -> shortcut, latency 1, L_o=1; mode 00 -> latency 2, G_o=1.
3. mode 10: A=0x80000000, B=0x00000000 -> E_o=1, latency 1; A=0xBF800000, B=0xC0000000 -> G_o=1, latency 2 (negative swap).
4. mode 10, A=0x7FC00000, B=0x3F800000 -> unord_o=1, L_o=G_o=E_o=0, latency 1; with CMP_MINMAX_EN, min_o=max_o=0x3F800000; with both NaN, both outputs 0x7FC00000.
5. Result with ready_i low for 3 cycles, new valid_i pulsed meanwhile -> outputs stable, ready_o=0, pulse ignored; ready_i high -> IDLE next edge, ready_o=1.
6. mode 00, equal operands 0xA5A5A5A5, rst_ni pulsed low during the 2nd SCAN cycle -> outputs 0 immediately, ready_o=1, no valid_o; a fresh compare afterwards gives E_o=1 at latency 5.
